// File: rtl/key_event_arbiter_if.sv
// Key/command bundle between the debouncer bank, the arbiter and the timer control.
// master: arbiter side. It receives the key pulses and levels and offers commands.
// slave : the debouncers and the consumer. They drive the keys and CMD_READY.
interface key_event_arbiter_if #(
    parameter int N_KEYS = 4
) ();
    localparam int IDW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] KEY_UP;     // per-key press/repeat pulses
    logic [N_KEYS-1:0] KEY_EN;     // per-key held level
    logic              CMD_VALID;  // command offered
    logic [IDW-1:0]    CMD_ID;     // key index of offered command
    logic              CMD_READY;  // consumer accepts command

    modport master (
        input  KEY_UP,
        input  KEY_EN,
        input  CMD_READY,
        output CMD_VALID,
        output CMD_ID
    );

    modport slave (
        output KEY_UP,
        output KEY_EN,
        output CMD_READY,
        input  CMD_VALID,
        input  CMD_ID
    );
endinterface

// File: rtl/key_event_arbiter.sv
// Purpose: This block generates the debounce strobes. It latches per-key events into PEND and
//          serves them round-robin as commands.
// Latency: An accepted KEY_UP sets PEND on the next edge. CMD_VALID rises one edge after that.
//          The arbiter delivers at most one command every two cycles.
// Backpressure: The arbiter holds a command in OFFER until CMD_READY. A repeat event on a key
//          that is still pending merges into the existing flag and sets the sticky OVF.
// Ports:   CLK/CLR_N are the clock and the async active-low reset.
//          SAMPLE_CE/REP_CE are the strobes to the debouncers.
//          bus carries KEY_UP/KEY_EN/CMD_*.
//          PEND gives the pending flags. LOCK gives the chord lockout.
//          OVF is the lost-event flag. OVF_CLR clears it.
module key_event_arbiter #(
    parameter int N_KEYS     = 4,
    parameter int SAMPLE_DIV = 50000,
    parameter int REP_DIV    = 8
) (
    input  logic                 CLK,
    input  logic                 CLR_N,
    output logic                 SAMPLE_CE,
    output logic                 REP_CE,
    key_event_arbiter_if.master  bus,
    output logic [N_KEYS-1:0]    PEND,
    output logic                 LOCK,
    output logic                 OVF,
    input  logic                 OVF_CLR
);
    localparam int IDW = $clog2(N_KEYS);
    localparam int SW  = $clog2(SAMPLE_DIV);
    localparam int RW  = (REP_DIV > 1) ? $clog2(REP_DIV) : 1;

    localparam logic [SW-1:0]  SMP_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0]  REP_LAST = RW'(REP_DIV - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(N_KEYS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Strobe generation. Both strobes are registered. SAMPLE_CE rises on the
    // edge where the counter leaves SAMPLE_DIV-1. The repetition count is
    // sampled on that same edge, so REP_CE coincides with every
    // REP_DIV-th SAMPLE_CE.
    // ------------------------------------------------------------------
    logic [SW-1:0] smp_cnt;
    logic [RW-1:0] rep_cnt;
    logic          smp_wrap;

    assign smp_wrap = (smp_cnt == SMP_LAST);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            smp_cnt   <= '0;
            rep_cnt   <= '0;
            SAMPLE_CE <= 1'b0;
            REP_CE    <= 1'b0;
        end else begin
            SAMPLE_CE <= smp_wrap;
            REP_CE    <= smp_wrap && (rep_cnt == REP_LAST);
            smp_cnt   <= smp_wrap ? '0 : smp_cnt + 1'b1;
            if (smp_wrap) begin
                rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Chord lockout. When two or more keys are held, x & (x-1) is non-zero.
    // ------------------------------------------------------------------
    assign LOCK = (bus.KEY_EN & (bus.KEY_EN - N_KEYS'(1))) != '0;

    logic [N_KEYS-1:0] acc_up;
    assign acc_up = LOCK ? '0 : bus.KEY_UP;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    state_t            state, state_nxt;
    logic [IDW-1:0]    cmd_id, cmd_id_nxt;
    logic [IDW-1:0]    ptr, ptr_nxt;
    logic [IDW-1:0]    sel_id;
    logic              sel_found;
    logic              hs;
    logic [N_KEYS-1:0] hs_mask;
    logic [N_KEYS-1:0] pend_nxt;
    logic              ovf_set;

    // Round-robin search. The first set PEND bit at or above PTR wins, wrapping modulo N_KEYS.
    always_comb begin
        int idx;
        sel_id    = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_KEYS) begin
                idx = idx - N_KEYS;
            end
            if (!sel_found && PEND[idx[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_id_nxt = cmd_id;
        ptr_nxt    = ptr;
        hs         = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    cmd_id_nxt = sel_id;
                    state_nxt  = OFFER;
                end
            end
            OFFER: begin
                if (bus.CMD_READY) begin
                    hs        = 1'b1;
                    ptr_nxt   = (cmd_id == ID_LAST) ? '0 : cmd_id + 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The consumed flag is cleared before new events are ORed in. A new
    // event on the key that is being handshaked therefore survives and is not
    // counted as lost.
    always_comb begin
        hs_mask = '0;
        if (hs) begin
            hs_mask[cmd_id] = 1'b1;
        end
        pend_nxt = (PEND & ~hs_mask) | acc_up;
        ovf_set  = |(acc_up & PEND & ~hs_mask);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state  <= IDLE;
            cmd_id <= '0;
            ptr    <= '0;
            PEND   <= '0;
            OVF    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cmd_id <= cmd_id_nxt;
            ptr    <= ptr_nxt;
            PEND   <= pend_nxt;
            // A new loss has priority over a clear in the same cycle.
            OVF    <= ovf_set | (OVF & ~OVF_CLR);
        end
    end

    assign bus.CMD_VALID = (state == OFFER);
    assign bus.CMD_ID    = cmd_id;

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;
    localparam int N = 4;

    logic       CLK;
    logic       CLR_N;
    logic       SAMPLE_CE;
    logic       REP_CE;
    logic [N-1:0] PEND;
    logic       LOCK;
    logic       OVF;
    logic       OVF_CLR;

    key_event_arbiter_if #(.N_KEYS(N)) bus ();

    key_event_arbiter #(
        .N_KEYS(N),
        .SAMPLE_DIV(4),
        .REP_DIV(3)
    ) dut (
        .CLK(CLK),
        .CLR_N(CLR_N),
        .SAMPLE_CE(SAMPLE_CE),
        .REP_CE(REP_CE),
        .bus(bus),
        .PEND(PEND),
        .LOCK(LOCK),
        .OVF(OVF),
        .OVF_CLR(OVF_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int id;
        int gap;   // required cycles since previous handshake, 0 = any
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_hs  = -100;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: each accepted command is compared against the queue.
    always @(negedge CLK) begin
        if (CLR_N && bus.CMD_VALID && bus.CMD_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cmd: got id %0d expected none", bus.CMD_ID);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cmd_id", 32'(bus.CMD_ID), 32'(e.id));
                if (e.gap != 0) check("cmd_gap", 32'(cyc - last_hs), 32'(e.gap));
            end
            last_hs = cyc;
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic push(input int id, input int gap);
        exp_t e;
        e.id  = id;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    initial begin
        CLR_N         = 1'b0;
        OVF_CLR       = 1'b0;
        bus.KEY_UP    = '0;
        bus.KEY_EN    = '0;
        bus.CMD_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_sample_ce", 32'(SAMPLE_CE), 0);
        check("rst_rep_ce",    32'(REP_CE), 0);
        check("rst_pend",      32'(PEND), 0);
        check("rst_valid",     32'(bus.CMD_VALID), 0);
        check("rst_id",        32'(bus.CMD_ID), 0);
        check("rst_ovf",       32'(OVF), 0);
        check("rst_lock",      32'(LOCK), 0);

        // Strobe pattern after reset release
        @(negedge CLK);
        CLR_N = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #2;
            check("sample_ce", 32'(SAMPLE_CE), 32'(k % 4 == 0));
            check("rep_ce",    32'(REP_CE),    32'(k % 12 == 0));
        end

        // All four keys at once with PTR=0
        bus.CMD_READY = 1'b1;
        push(0, 0); push(1, 2); push(2, 2); push(3, 2);
        bus.KEY_UP = 4'b1111;
        step();
        bus.KEY_UP = '0;
        check("burst_pend", 32'(PEND), 32'hF);
        drain("burst0");

        // Single event timing
        push(0, 0);
        bus.KEY_UP = 4'b0001;
        step();
        bus.KEY_UP = '0;
        check("single_pend",   32'(PEND), 1);
        check("single_valid0", 32'(bus.CMD_VALID), 0);
        step();
        check("single_valid1", 32'(bus.CMD_VALID), 1);
        check("single_id",     32'(bus.CMD_ID), 0);
        step();
        check("single_pend0",  32'(PEND), 0);
        check("single_valid2", 32'(bus.CMD_VALID), 0);

        // Move PTR to 2 and replay the burst
        push(1, 0);
        bus.KEY_UP = 4'b0010;
        step();
        bus.KEY_UP = '0;
        drain("key1");
        push(2, 0); push(3, 2); push(0, 2); push(1, 2);
        bus.KEY_UP = 4'b1111;
        step();
        bus.KEY_UP = '0;
        drain("burst2");

        // Chord lockout discards events
        bus.KEY_EN = 4'b0011;
        bus.KEY_UP = 4'b0001;
        #1;
        check("lock_on", 32'(LOCK), 1);
        step();
        bus.KEY_UP = '0;
        check("lock_pend", 32'(PEND), 0);
        check("lock_ovf",  32'(OVF), 0);
        bus.KEY_EN = '0;
        #1;
        check("lock_off", 32'(LOCK), 0);

        // Several keys in one cycle with one held (PTR=2)
        bus.KEY_EN = 4'b0001;
        bus.KEY_UP = 4'b0101;
        push(2, 0); push(0, 2);
        #1;
        check("multi_lock", 32'(LOCK), 0);
        step();
        bus.KEY_UP = '0;
        bus.KEY_EN = '0;
        check("multi_pend", 32'(PEND), 32'h5);
        drain("multi");

        // Overflow and clearing it
        bus.CMD_READY = 1'b0;
        bus.KEY_UP = 4'b0010;
        step();
        bus.KEY_UP = '0;
        check("ovf_pend1", 32'(PEND), 32'h2);
        check("ovf_none",  32'(OVF), 0);
        step();
        bus.KEY_UP = 4'b0010;
        step();
        check("ovf_set",   32'(OVF), 1);
        check("ovf_pend2", 32'(PEND), 32'h2);
        OVF_CLR = 1'b1;
        step();
        bus.KEY_UP = '0;
        check("ovf_set_wins", 32'(OVF), 1);
        step();
        OVF_CLR = 1'b0;
        check("ovf_cleared", 32'(OVF), 0);

        // A new event coincides with the handshake of the same key
        push(1, 0); push(1, 2);
        bus.CMD_READY = 1'b1;
        bus.KEY_UP = 4'b0010;
        step();
        bus.KEY_UP = '0;
        check("coinc_pend", 32'(PEND), 32'h2);
        check("coinc_ovf",  32'(OVF), 0);
        drain("coinc");

        // Reset during OFFER (PTR=2)
        bus.CMD_READY = 1'b0;
        bus.KEY_UP = 4'b0110;
        step();
        bus.KEY_UP = '0;
        step();
        check("pre_valid", 32'(bus.CMD_VALID), 1);
        check("pre_id",    32'(bus.CMD_ID), 2);
        check("pre_pend",  32'(PEND), 32'h6);
        bus.KEY_UP = 4'b0010;
        step();
        bus.KEY_UP = '0;
        check("pre_ovf", 32'(OVF), 1);
        #1;
        CLR_N = 1'b0;
        #1;
        check("arst_valid",  32'(bus.CMD_VALID), 0);
        check("arst_pend",   32'(PEND), 0);
        check("arst_ovf",    32'(OVF), 0);
        check("arst_id",     32'(bus.CMD_ID), 0);
        check("arst_sample", 32'(SAMPLE_CE + REP_CE), 0);
        @(negedge CLK);
        CLR_N = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #2;
            check("resume_sample", 32'(SAMPLE_CE), 32'(k == 4));
        end
        bus.CMD_READY = 1'b1;
        repeat (3) step();
        check("post_valid", 32'(bus.CMD_VALID), 0);
        check("post_pend",  32'(PEND), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of debounced key channels served (2..8).
REQ-002 SHALL have parameter SAMPLE_DIV, default 50000, CLK cycles per SAMPLE_CE strobe (>=2).
REQ-003 SHALL have parameter REP_DIV, default 8, SAMPLE_CE strobes per REP_CE strobe (>=1).
REQ-004 SHALL have port CLK  in  1  single system clock, all state on rising edge.
REQ-005 SHALL have port CLR_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SAMPLE_CE  out  1  debounce shift-register enable strobe to all debouncers.
REQ-007 SHALL have port REP_CE  out  1  repetition-prescaler enable strobe to all debouncers.
REQ-008 SHALL have port KEY_UP  in  N_KEYS  per-key press/repeat pulses from debouncers.
REQ-009 SHALL have port KEY_EN  in  N_KEYS  per-key held level from debouncers.
REQ-010 SHALL have port CMD_VALID  out  1  command offered to timer control.
REQ-011 SHALL have port CMD_ID  out  clog2(N_KEYS)  index of key for offered command.
REQ-012 SHALL have port CMD_READY  in  1  consumer accepts command.
REQ-013 SHALL have port PEND  out  N_KEYS  pending-event flags (registered).
REQ-014 SHALL have port LOCK  out  1  chord lockout active (combinational from KEY_EN).
REQ-015 SHALL have port OVF  out  1  sticky event-lost flag; port OVF_CLR  in  1  clears it.

Function
REQ-016 SHALL count sample counter 0..SAMPLE_DIV-1 wrapping to 0; SAMPLE_CE=1 for exactly one cycle when count==SAMPLE_DIV-1 (registered output, first pulse SAMPLE_DIV cycles after reset release).
REQ-017 SHALL count SAMPLE_CE strobes modulo REP_DIV; REP_CE asserted same cycle as SAMPLE_CE when repetition count==REP_DIV-1; REP_DIV=1 gives REP_CE==SAMPLE_CE.
REQ-018 SHALL assert LOCK whenever two or more KEY_EN bits are 1 in the current cycle.
REQ-019 SHALL accept KEY_UP[i] only when LOCK==0; accepted pulse sets PEND[i] next edge; pulses during LOCK are discarded without OVF.
REQ-020 SHALL use FSM states IDLE and OFFER; IDLE: CMD_VALID=0; if PEND!=0, select first set bit searching from PTR upward modulo N_KEYS, register CMD_ID, go OFFER.
REQ-021 SHALL in OFFER hold CMD_VALID=1 and CMD_ID stable until CMD_READY=1; on that edge clear PEND[CMD_ID], set PTR=(CMD_ID+1) mod N_KEYS, go IDLE.
REQ-022 SHALL therefore deliver at most one command per two cycles; CMD_READY while CMD_VALID=0 has no effect.
REQ-023 SHALL keep PEND[i]=1 with no OVF when accepted KEY_UP[i] coincides with handshake of key i (new event replaces consumed one).
REQ-024 SHALL set OVF when accepted KEY_UP[i] arrives with PEND[i]=1 and no handshake on key i that cycle; event is merged (PEND stays 1).
REQ-025 SHALL clear OVF on OVF_CLR=1; simultaneous set condition wins (OVF stays 1).
REQ-026 SHALL allow several KEY_UP bits in one cycle (LOCK=0 case, e.g. one held plus one released edge) to set several PEND bits at once.
REQ-027 SHALL not gate PEND updates by SAMPLE_CE; inputs are sampled every CLK.

Reset
REQ-028 SHALL on CLR_N=0 asynchronously force: counters 0, SAMPLE_CE=0, REP_CE=0, PEND=0, PTR=0, state IDLE, CMD_VALID=0, CMD_ID=0, OVF=0.
REQ-029 SHALL on reset mid-OFFER drop CMD_VALID immediately and discard the offered and all pending events.
REQ-030 SHALL resume counting from 0 on the first CLK edge after CLR_N deasserts.

Verification
REQ-031 SAMPLE_DIV=4, REP_DIV=3, free run 40 cycles -> SAMPLE_CE at cycles 4,8,12,...; REP_CE at 12,24,36 only.
REQ-032 KEY_UP=0001 one cycle, CMD_READY=1 held -> PEND=0001 next edge, CMD_VALID=1 with CMD_ID=0 one cycle later, PEND=0 after accept.
REQ-033 KEY_UP=1111 one cycle, CMD_READY=1 -> CMD_IDs 0,1,2,3 in order, one per two cycles; repeat with PTR=2 -> order 2,3,0,1.
REQ-034 KEY_EN=0011, KEY_UP=0001 -> LOCK=1, PEND stays 0000, OVF=0.
REQ-035 CMD_READY=0, KEY_UP[1] pulsed twice -> OVF=1, PEND=0010; OVF_CLR with third pulse same cycle -> OVF stays 1.
REQ-036 CLR_N low during OFFER with PEND=0110 -> CMD_VALID, PEND, OVF, counters all 0 without waiting for CLK.
